// File: rtl/add_fp_pipe.sv
// -----------------------------------------------------------------------------
// add_fp_pipe
// Three-stage pipelined floating-point adder/subtractor for the PE datapath.
// Round-to-nearest-even, subnormal inputs read as signed zero, results that
// would be subnormal are flushed to signed zero.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_sub=1 computes a-b, else a+b
//   a, b              operands packed {sign, exponent, fraction}
//   out_valid/out_ready result handshake
//   sum               result word
//   flag_ovf          finite operands rounded to infinity
//   flag_unf          nonzero exact result flushed to zero
//   flag_inv          +inf combined with -inf; sum is the canonical NaN
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are 1. The three stages advance together whenever the output
// slot is empty or being drained (adv = !out_valid || out_ready); in_ready is
// exactly adv, so a stalled consumer freezes every stage, and bubbles drain
// without consumer action. A sender holds its word stable until it is taken.
// -----------------------------------------------------------------------------
module add_fp_pipe #(
    parameter int EXPONENTWIDTH = 8,
    parameter int MANTISSAWIDTH = 23,
    parameter int WIDTH         = 1 + EXPONENTWIDTH + MANTISSAWIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inv
);
    localparam int E      = EXPONENTWIDTH;
    localparam int M      = MANTISSAWIDTH;
    localparam int MW     = M + 4;                      // hidden + fraction + guard/round/sticky
    localparam int SW     = M + 5;                      // adds carry-out
    localparam int SH_MAX = M + 3;                      // shifts this far leave only sticky
    localparam int XW     = E + $clog2(M + 5) + 2;      // two's-complement working exponent
    localparam logic [E-1:0] EXP_ONES = '1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: classify and align (combinational from the operand ports)
    // ------------------------------------------------------------------
    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb, fa_eff, fb_eff;
    logic         a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge;

    assign sa = a[WIDTH-1];
    assign sb = b[WIDTH-1] ^ in_sub;
    assign ea = a[WIDTH-2:M];
    assign eb = b[WIDTH-2:M];
    assign fa = a[M-1:0];
    assign fb = b[M-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);

    // Subnormals carry no magnitude, so their fraction is ignored everywhere.
    assign fa_eff = a_zero ? '0 : fa;
    assign fb_eff = b_zero ? '0 : fb;
    assign a_ge   = {ea, fa_eff} >= {eb, fb_eff};

    logic         sl, ss;
    logic [E-1:0] el, es, d;
    logic [M:0]   ml, ms;

    always_comb begin
        if (a_ge) begin
            sl = sa; el = ea; ml = {!a_zero, fa_eff};
            ss = sb; es = eb; ms = {!b_zero, fb_eff};
        end else begin
            sl = sb; el = eb; ml = {!b_zero, fb_eff};
            ss = sa; es = ea; ms = {!a_zero, fa_eff};
        end
    end

    assign d = el - es;

    // The upper half of align_wide is the shifted mantissa with guard and
    // round; whatever falls into the lower half is folded into sticky.
    logic [2*(M+3)-1:0] align_wide;
    logic [M+2:0]       small_sh;
    logic               small_st;

    always_comb begin
        align_wide = {ms, 2'b00, {(M + 3){1'b0}}} >> d;
        if (32'(d) >= SH_MAX) begin
            small_sh = '0;
            small_st = |ms;
        end else begin
            small_sh = align_wide[2*(M+3)-1 -: (M + 3)];
            small_st = |align_wide[M+2:0];
        end
    end

    logic          s1_valid, s1_sign, s1_sub, s1_nan, s1_inv, s1_inf, s1_inf_sign, s1_neg_zero;
    logic [E-1:0]  s1_exp;
    logic [MW-1:0] s1_mag_l, s1_mag_s;

    // ------------------------------------------------------------------
    // Stage 2: add or subtract magnitudes (larger minus smaller)
    // ------------------------------------------------------------------
    logic [SW-1:0] sum_d;
    assign sum_d = s1_sub ? ({1'b0, s1_mag_l} - {1'b0, s1_mag_s})
                          : ({1'b0, s1_mag_l} + {1'b0, s1_mag_s});

    logic          s2_valid, s2_sign, s2_nan, s2_inv, s2_inf, s2_inf_sign, s2_neg_zero;
    logic [E-1:0]  s2_exp;
    logic [SW-1:0] s2_sum;

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, resolve specials
    // ------------------------------------------------------------------
    logic [XW-1:0] lzc, exp_n, exp_fin;
    logic [MW-1:0] norm;
    logic [M:0]    keep;
    logic [M+1:0]  rounded;
    logic [M-1:0]  frac;
    logic          rnd_up, sum_zero, exp_ovf, exp_unf;
    logic [WIDTH-1:0] res_d;
    logic          ovf_d, unf_d, inv_d;

    // Leading zeros of the non-carry part of the sum.
    always_comb begin
        lzc = XW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (s2_sum[i]) lzc = XW'(MW - 1 - i);
        end
    end

    always_comb begin
        if (s2_sum[SW-1]) begin
            // Carry-out: the bit dropped off the bottom joins sticky.
            norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            exp_n = XW'(s2_exp) + XW'(1);
        end else begin
            // Only close-exponent cancellation shifts by more than one, and
            // then the low bits are exact, so shifting in zeros is correct.
            norm  = s2_sum[MW-1:0] << lzc;
            exp_n = XW'(s2_exp) - lzc;
        end
        keep    = norm[MW-1:3];
        rnd_up  = norm[2] && (norm[1] || norm[0] || keep[0]);
        rounded = {1'b0, keep} + (M + 2)'(rnd_up);
        // On rounding overflow the mantissa is 10..0 and shifts down by one.
        frac    = rounded[M+1] ? rounded[M:1] : rounded[M-1:0];
        exp_fin = exp_n + XW'(rounded[M+1]);
    end

    assign sum_zero = (s2_sum == '0);
    assign exp_ovf  = !exp_fin[XW-1] && (exp_fin >= XW'(EXP_ONES));
    assign exp_unf  = exp_fin[XW-1] || (exp_fin == '0);

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
        if (s2_nan) begin
            res_d = {1'b0, EXP_ONES, 1'b1, {(M - 1){1'b0}}};
            inv_d = s2_inv;
        end else if (s2_inf) begin
            res_d = {s2_inf_sign, EXP_ONES, {M{1'b0}}};
        end else if (sum_zero) begin
            res_d = {s2_neg_zero, {(WIDTH - 1){1'b0}}};
        end else if (exp_ovf) begin
            res_d = {s2_sign, EXP_ONES, {M{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_unf) begin
            res_d = {s2_sign, {(WIDTH - 1){1'b0}}};
            unf_d = 1'b1;
        end else begin
            res_d = {s2_sign, exp_fin[E-1:0], frac};
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: all three stages move together on adv
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_nan      <= 1'b0;
            s1_inv      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
            s1_neg_zero <= 1'b0;
            s1_exp      <= '0;
            s1_mag_l    <= '0;
            s1_mag_s    <= '0;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_nan      <= 1'b0;
            s2_inv      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
            s2_neg_zero <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            out_valid   <= 1'b0;
            sum         <= '0;
            flag_ovf    <= 1'b0;
            flag_unf    <= 1'b0;
            flag_inv    <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid;
            s1_sign     <= sl;
            s1_sub      <= (sl != ss);
            s1_nan      <= a_nan || b_nan || (a_inf && b_inf && (sa != sb));
            s1_inv      <= a_inf && b_inf && (sa != sb);
            s1_inf      <= a_inf || b_inf;
            s1_inf_sign <= a_inf ? sa : sb;
            s1_neg_zero <= a_zero && b_zero && sa && sb;
            s1_exp      <= el;
            s1_mag_l    <= {ml, 3'b000};
            s1_mag_s    <= {small_sh, small_st};

            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_nan      <= s1_nan;
            s2_inv      <= s1_inv;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
            s2_neg_zero <= s1_neg_zero;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_d;

            out_valid   <= s2_valid;
            sum         <= res_d;
            flag_ovf    <= ovf_d;
            flag_unf    <= unf_d;
            flag_inv    <= inv_d;
        end
    end

endmodule

// File: tb/tb_add_fp_pipe.sv
// -----------------------------------------------------------------------------
// tb_add_fp_pipe
// Bench for add_fp_pipe: a single-precision instance and a half-precision
// instance share the clock and reset. Expected results come from an exact
// big-integer reference adder with round-to-nearest-even.
// -----------------------------------------------------------------------------
module tb_add_fp_pipe;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // single-precision instance
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        flag_ovf, flag_unf, flag_inv;
    logic [31:0] a, b, sum;

    add_fp_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
    );

    // half-precision instance
    logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
    logic        h_flag_ovf, h_flag_unf, h_flag_inv;
    logic [15:0] h_a, h_b, h_sum;

    add_fp_pipe #(.EXPONENTWIDTH(5), .MANTISSAWIDTH(10)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_sub(h_in_sub),
        .a(h_a), .b(h_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .sum(h_sum), .flag_ovf(h_flag_ovf), .flag_unf(h_flag_unf), .flag_inv(h_flag_inv)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard entries are {ovf, unf, inv, sum zero-extended to 32 bits}
    logic [34:0] exp_q[$];

    // ------------------------------------------------------------------
    // Reference model: operands become exact integers in units of the
    // smallest normal ulp, are added exactly, then rounded to nearest-even.
    // ------------------------------------------------------------------
    function automatic logic [34:0] ref_add(input int ew, input int mw,
                                            input logic [31:0] a_in,
                                            input logic [31:0] b_in,
                                            input logic sub);
        int emax, ea, eb, p, e, sh;
        logic sa, sb, sr;
        logic [31:0] fa, fb, fmask, nan_w, sign_w;
        logic [319:0] va, vb, r, sig, rem, half;
        emax   = (1 << ew) - 1;
        fmask  = (32'd1 << mw) - 32'd1;
        sa     = a_in[ew+mw];
        sb     = b_in[ew+mw] ^ sub;
        ea     = int'((a_in >> mw) & 32'(emax));
        eb     = int'((b_in >> mw) & 32'(emax));
        fa     = a_in & fmask;
        fb     = b_in & fmask;
        nan_w  = (32'(emax) << mw) | (32'd1 << (mw - 1));
        if ((ea == emax && fa != 0) || (eb == emax && fb != 0)) return {3'b000, nan_w};
        if (ea == emax && eb == emax) begin
            if (sa != sb) return {3'b001, nan_w};
            return {3'b000, ({31'd0, sa} << (ew + mw)) | (32'(emax) << mw)};
        end
        if (ea == emax) return {3'b000, ({31'd0, sa} << (ew + mw)) | (32'(emax) << mw)};
        if (eb == emax) return {3'b000, ({31'd0, sb} << (ew + mw)) | (32'(emax) << mw)};
        va = (ea == 0) ? '0 : ({288'd0, fa | (32'd1 << mw)} << (ea - 1));
        vb = (eb == 0) ? '0 : ({288'd0, fb | (32'd1 << mw)} << (eb - 1));
        if (sa == sb) begin r = va + vb; sr = sa; end
        else if (va >= vb) begin r = va - vb; sr = sa; end
        else begin r = vb - va; sr = sb; end
        if (r == '0) begin
            if (ea == 0 && eb == 0 && sa && sb) return {3'b000, 32'd1 << (ew + mw)};
            return 35'd0;
        end
        sign_w = {31'd0, sr} << (ew + mw);
        p = 0;
        for (int i = 0; i < 320; i++) if (r[i]) p = i;
        e = p - mw + 1;
        if (p > mw) begin
            sh   = p - mw;
            sig  = r >> sh;
            rem  = r & ((320'd1 << sh) - 320'd1);
            half = 320'd1 << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 320'd1;
            if (sig[mw+1]) begin sig = sig >> 1; e = e + 1; end
        end else begin
            sig = r << (mw - p);
        end
        if (e >= emax) return {3'b100, sign_w | (32'(emax) << mw)};
        if (e <= 0) return {3'b010, sign_w};
        return {3'b000, sign_w | (32'(e) << mw) | (sig[31:0] & fmask)};
    endfunction

    function automatic logic [31:0] rand_f32();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 9);
        if (k < 4) r[30:23] = 8'($urandom_range(100, 154));
        else if (k == 4) r[30:23] = 8'($urandom_range(250, 254));
        else if (k == 5) r[30:23] = 8'($urandom_range(1, 3));
        else if (k == 6) begin
            case ($urandom_range(0, 5))
                0: r = 32'h0000_0000;
                1: r = 32'h8000_0000;
                2: r = 32'h7F80_0000;
                3: r = 32'hFF80_0000;
                4: r = 32'h7FA0_0001;
                default: r[30:23] = 8'h00;
            endcase
        end
        return r;
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid    = 1'b0;
        in_sub      = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b1;
        h_in_valid  = 1'b0;
        h_in_sub    = 1'b0;
        h_a         = '0;
        h_b         = '0;
        h_out_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        checks++;
        if ({out_valid, sum, flag_ovf, flag_unf, flag_inv} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b sum=%h flags=%b%b%b, expected all 0",
                     out_valid, sum, flag_ovf, flag_unf, flag_inv);
        end
        checks++;
        if (in_ready !== 1'b1 || h_out_valid !== 1'b0 || h_sum !== 16'd0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b h_out_valid=%b h_sum=%h, expected 1 0 0000",
                     in_ready, h_out_valid, h_sum);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: out_valid=%b, expected 0", out_valid);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_latency();
        logic [31:0] va[5], vb[5], vr[5];
        logic        vs[5];
        va = '{32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h41A66666, 32'hC1A66666};
        vb = '{32'h3E800000, 32'h3E800000, 32'h40200000, 32'h3F99999A, 32'hBF99999A};
        vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vr = '{32'h3FE00000, 32'h3FA00000, 32'hBF800000, 32'h41B00000, 32'hC1B00000};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            checks++;
            if (cyc >= 3 && cyc < 8) begin
                if (out_valid !== 1'b1 || sum !== vr[cyc-3] ||
                    {flag_ovf, flag_unf, flag_inv} !== 3'b000) begin
                    errors++;
                    $display("FAIL basic_latency op%0d: out_valid=%b sum=%h flags=%b%b%b, expected 1 %h 000",
                             cyc - 3, out_valid, sum, flag_ovf, flag_unf, flag_inv, vr[cyc-3]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_latency cycle%0d: out_valid=%b, expected 0", cyc, out_valid);
            end
            if (cyc < 5) begin
                in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; in_sub = vs[cyc];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_specials();
        logic [31:0] va[8], vb[8], vr[8];
        logic        vs[8];
        logic [2:0]  vf[8];
        va = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF,
               32'h7F800000, 32'h40400000, 32'h80000000, 32'h00800001};
        vb = '{32'h33800000, 32'h33800001, 32'h33800000, 32'h7F7FFFFF,
               32'h7F800000, 32'h40400000, 32'h80000000, 32'h00800000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vr = '{32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h7F800000,
               32'h7FC00000, 32'h00000000, 32'h80000000, 32'h00000000};
        vf = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b000, 3'b000, 3'b010};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (cyc >= 3 && cyc < 11) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== vr[cyc-3] ||
                    {flag_ovf, flag_unf, flag_inv} !== vf[cyc-3]) begin
                    errors++;
                    $display("FAIL round_specials op%0d: out_valid=%b sum=%h ovf/unf/inv=%b%b%b, expected 1 %h %b",
                             cyc - 3, out_valid, sum, flag_ovf, flag_unf, flag_inv, vr[cyc-3], vf[cyc-3]);
                end
            end
            if (cyc < 8) begin
                in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; in_sub = vs[cyc];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        int          sent, got;
        logic        stalled, pending;
        logic [34:0] held, got_w, exp_w;
        sent = 0; got = 0; stalled = 1'b0; pending = 1'b0; held = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {flag_ovf, flag_unf, flag_inv, sum} !== held) begin
                    errors++;
                    $display("FAIL bp_hold: out_valid=%b word=%h, expected 1 %h",
                             out_valid, {flag_ovf, flag_unf, flag_inv, sum}, held);
                end
            end
            out_ready = (cyc % 3 == 0);
            if (!pending) in_valid = 1'b0;
            if (!pending && sent < 6) begin
                a = rand_f32(); b = rand_f32(); in_sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1; pending = 1'b1;
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready: in_ready=%b with out_valid=%b out_ready=%b, expected %b",
                         in_ready, out_valid, out_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                got_w = {flag_ovf, flag_unf, flag_inv, sum};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: unexpected result %h, expected none", got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("FAIL bp_result: got %h, expected %h", got_w, exp_w);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(8, 23, a, b, in_sub));
                sent++;
                pending = 1'b0;
            end
            stalled = out_valid && !out_ready;
            held    = {flag_ovf, flag_unf, flag_inv, sum};
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: results=%0d left=%0d, expected 6 and 0", got, exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic        pending;
        logic [34:0] got_w, exp_w;
        pending = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 460; cyc++) begin
            step();
            out_ready = (cyc >= 420) || ($urandom_range(0, 3) != 0);
            if (!pending) in_valid = 1'b0;
            if (!pending && cyc < 400 && $urandom_range(0, 4) != 0) begin
                a = rand_f32();
                b = rand_f32();
                if ($urandom_range(0, 1) == 1) b[30:23] = a[30:23] - 8'($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0] ^ 23'($urandom_range(0, 7));
                in_sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                pending = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                got_w = {flag_ovf, flag_unf, flag_inv, sum};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra: unexpected result %h, expected none", got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("FAIL random_result: got %h, expected %h", got_w, exp_w);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(8, 23, a, b, in_sub));
                pending = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || pending) begin
            errors++;
            $display("FAIL random_drain: %0d results outstanding (pending=%b), expected 0",
                     exp_q.size(), pending);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1'b1; a = rand_f32(); b = rand_f32(); in_sub = 1'b0;
        end
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, sum, flag_ovf, flag_unf, flag_inv} !== 36'd0) begin
            errors++;
            $display("FAIL rstmid_async: out_valid=%b sum=%h flags=%b%b%b, expected all 0",
                     out_valid, sum, flag_ovf, flag_unf, flag_inv);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale: out_valid=%b sum=%h after release, expected 0", out_valid, sum);
            end
        end
        in_valid = 1'b1; a = 32'h3FC00000; b = 32'h3E800000; in_sub = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            step();
            in_valid = 1'b0;
            checks++;
            if (cyc < 3 && out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_early: out_valid=%b at cycle %0d, expected 0", out_valid, cyc);
            end else if (cyc == 3 && (out_valid !== 1'b1 || sum !== 32'h3FE00000)) begin
                errors++;
                $display("FAIL rstmid_latency: out_valid=%b sum=%h, expected 1 3fe00000", out_valid, sum);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_half();
        logic [34:0] got_w, exp_w;
        int          n_out;
        n_out = 0;
        exp_q.delete();
        h_out_ready = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            step();
            h_in_valid = 1'b0;
            if (cyc == 0) begin
                h_in_valid = 1'b1; h_a = 16'h3E00; h_b = 16'h3400; h_in_sub = 1'b0;
                exp_q.push_back({3'b000, 32'h0000_3F00});
            end else if (cyc == 1) begin
                h_in_valid = 1'b1; h_a = 16'h7BFF; h_b = 16'h7BFF; h_in_sub = 1'b0;
                exp_q.push_back({3'b100, 32'h0000_7C00});
            end else if (cyc < 60) begin
                h_in_valid = 1'b1;
                h_a = 16'($urandom());
                h_b = 16'($urandom());
                if ($urandom_range(0, 1) == 1) h_b[14:10] = h_a[14:10];
                h_in_sub = 1'($urandom_range(0, 1));
                exp_q.push_back(ref_add(5, 10, {16'd0, h_a}, {16'd0, h_b}, h_in_sub));
            end
            if (h_out_valid) begin
                checks++;
                got_w = {h_flag_ovf, h_flag_unf, h_flag_inv, 16'd0, h_sum};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL half_extra: unexpected result %h, expected none", got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("FAIL half_result #%0d: got %h, expected %h", n_out, got_w, exp_w);
                    end
                end
                n_out++;
            end
        end
        checks++;
        if (exp_q.size() != 0 || n_out != 60) begin
            errors++;
            $display("FAIL half_count: results=%0d left=%0d, expected 60 and 0", n_out, exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic_latency();
        test_round_specials();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_half();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_fp_pipe.md
# add_fp_pipe

Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor for the PE datapath. It is the clocked successor to the combinational `add_f32` and adds the following: configurable exponent and mantissa widths, per-operation add/subtract select, round-to-nearest-even, special-value handling and status flags. It has a valid/ready handshake with full backpressure and sits between the PE operand registers and the accumulator writeback.

## Interface
- `EXPONENTWIDTH`, default 8: exponent field width, minimum 3.
- `MANTISSAWIDTH`, default 23: stored fraction width, minimum 2.
- `WIDTH`, default 1+EXPONENTWIDTH+MANTISSAWIDTH: word width, derived, never overridden.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: operand pair present.
- `in_ready`  out  1: pipeline accepts operands this cycle.
- `in_sub`  in  1: 1 selects a−b, 0 selects a+b.
- `a`, `b`  in  WIDTH: operands, packed {sign, exp, mant}.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts result.
- `sum`  out  WIDTH: result word.
- `flag_ovf`  out  1: finite operands rounded to infinity.
- `flag_unf`  out  1: nonzero exact result flushed to zero.
- `flag_inv`  out  1: invalid operation; result is the canonical NaN.

## Operation
- **Transfer rules:**
  - Input transfer happens when `in_valid` && `in_ready`.
  - Output transfer happens when `out_valid` && `out_ready`.
- **Global advance:** the pipeline advances as one unit when adv = !out_valid || out_ready.
- **Input ready:** `in_ready` = adv, combinational.
- **Stage valids:** each stage carries a valid bit; a bubble still occupies its slot.
- **Operand preprocessing:** with `in_sub`=1, b's sign is inverted before any other processing.
- **Subnormals:** a subnormal input (exp=0) is treated as a signed zero.
- **Stage 1, classify and align:**
  - Detect zero, infinity and NaN (exp all ones with mant≠0) on each operand.
  - Select the larger-magnitude operand by comparing {exp, mant}.
  - Prepend the hidden 1 to both mantissas.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits (sticky is the OR of all bits shifted out).
  - Shifts of MANTISSAWIDTH+3 or more leave only sticky.
- **Stage 2, add/subtract:**
  - Like signs: add magnitudes into a MANTISSAWIDTH+5 bit sum (the extra bit holds carry-out).
  - Unlike signs: subtract smaller from larger.
  - The result sign is the sign of the larger operand.
- **Stage 3, normalise and round:**
  - On carry-out, shift right 1 (the lost bit folds into sticky) and increment the exponent.
  - Otherwise, left-normalise using a leading-zero count and decrement the exponent.
  - Round to nearest, ties to even.
  - If rounding overflows the mantissa, renormalise and increment the exponent.
- **Special results (precedence top to bottom):**
  - Any NaN input → 0 + all-ones exp + mant 1000…0. `flag_inv` is set only when +inf and −inf are combined.
  - Infinity input → that infinity.
  - Exact zero magnitude → +0, except (−0)+(−0) → −0.
  - Final exponent ≥ all-ones → ±infinity and `flag_ovf`.
  - Final exponent ≤ 0 → ±0 and `flag_unf`.
- **Flag timing:** flags are valid only while `out_valid`=1 and belong to the presented result.

## Timing
- **Latency:** exactly 3 cycles from input transfer to `out_valid` when `out_ready` is held at 1.
- **Throughput:** one result per cycle.
- **Backpressure:**
  - While `out_valid`=1 and `out_ready`=0, all stages hold their contents.
  - `in_ready`=0 during this stall.
  - `sum` and the flags stay stable.
- **Fill:** `in_ready`=1 whenever `out_valid`=0, so bubbles drain without consumer action.
- **Reset values:** `out_valid`, all stage valids, `sum`, `flag_ovf`, `flag_unf` and `flag_inv` are 0.
- **Reset mid-operation:** in-flight operations are discarded. No result emerges for them after release.
- **Simultaneous events:** an input and an output transfer in the same cycle are both honoured and nothing is lost.

## Test plan
- **Basic add/sub, latency:** apply `out_ready`=1 and the following, one per cycle. Results must appear in order exactly 3 cycles after each input.
  - 0x3FC00000 + 0x3E800000 → 0x3FE00000.
  - 0x3FC00000 − 0x3E800000 → 0x3FA00000.
  - 0x3FC00000 − 0x40200000 → 0xBF800000.
  - 0x41A66666 + 0x3F99999A → 0x41B00000.
  - 0xC1A66666 + 0xBF99999A → 0xC1B00000.
- **Rounding:**
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie, stays even).
  - 0x3F800000 + 0x33800001 → 0x3F800001.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- **Specials and flags:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `flag_ovf`=1.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, `flag_inv`=1.
  - 0x40400000 − 0x40400000 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x00800001 − 0x00800000 → 0x00000000, `flag_unf`=1.
- **Backpressure:**
  - Stream 6 operations with `out_ready` toggling 1,0,0,1,…
  - No result is dropped or duplicated.
  - `sum` holds during stalls.
  - `in_ready` falls in the same cycle `out_ready`=0 with `out_valid`=1.
- **Reset mid-stream:**
  - Assert `rst` for 1 cycle with 3 operations in flight.
  - All outputs read 0 immediately and no stale `out_valid` appears afterward.
  - The next operation after release has 3-cycle latency.
- **Parametrisation:** with EXPONENTWIDTH=5 and MANTISSAWIDTH=10 (half precision):
  - 0x3E00 + 0x3400 → 0x3F00.
  - 0x7BFF + 0x7BFF → 0x7C00 with `flag_ovf`.
